// File: rtl/bldc_pwm_multi.sv
// bldc_pwm_multi
// Multi-channel complementary PWM generator for the BLDC ESC power stage.
// All channels share one edge-aligned period counter (0..period-1). Each
// channel compares the counter against its own duty value to get a raw
// reference, then drives a high-side/low-side gate pair from it. Period,
// duty and dead-time are double-buffered and change only at a boundary:
// a wrap, or any cycle where the block is idle (pwm_en low or period 0).
//
// Optional feature macro: PWM_DEADTIME_EN
//   defined   : per-channel dead-time FSM, dead counters and dead_time port
//   undefined : pwm_hi = raw, pwm_lo = ~raw (registered); dead_time ignored
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   pwm_en       enable; low forces all gate outputs low
//   pwm_period   period in clk cycles (staged on load)
//   duty         per-channel high time, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   dead_time    dead-time in clk cycles, shared by all channels (staged on load)
//   load         one-cycle strobe capturing period/duty/dead_time
//   pwm_hi       high-side gate command per channel
//   pwm_lo       low-side gate command per channel
//   period_start one-cycle pulse in the cnt==0 cycle after a wrap or enable
//   load_pending staged values waiting for the next boundary
//
// Dead-time FSM (per channel, PWM_DEADTIME_EN only)
//   state  | meaning
//   ST_OFF | not running; next running cycle is treated as a raw edge
//   ST_DT  | both outputs low, dead counter running toward the raw side
//   ST_HI  | high-side on, raw has stayed high
//   ST_LO  | low-side on, raw has stayed low
module bldc_pwm_multi #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 3,
  parameter int DT_WIDTH   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           pwm_en,
  input  logic [DATA_WIDTH-1:0]          pwm_period,
  input  logic [CHANNELS*DATA_WIDTH-1:0] duty,
  input  logic [DT_WIDTH-1:0]            dead_time,
  input  logic                           load,
  output logic [CHANNELS-1:0]            pwm_hi,
  output logic [CHANNELS-1:0]            pwm_lo,
  output logic                           period_start,
  output logic                           load_pending
);

  logic [DATA_WIDTH-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]          period_act_q, period_act_d;
  logic [DATA_WIDTH-1:0]          period_stg_q, period_stg_d;
  logic [CHANNELS*DATA_WIDTH-1:0] duty_act_q, duty_act_d;
  logic [CHANNELS*DATA_WIDTH-1:0] duty_stg_q, duty_stg_d;
  logic                           load_pending_q, load_pending_d;
  logic                           period_start_q, period_start_d;
  logic                           run_q, run_d;
  logic [CHANNELS-1:0]            hi_q, hi_d;
  logic [CHANNELS-1:0]            lo_q, lo_d;

  logic                           run_ok;
  logic                           go;
  logic                           wrap;
  logic                           boundary;
  logic [CHANNELS-1:0]            raw;

  // run_q marks that the previous cycle was already enabled with a valid
  // period; the first enabled cycle only arms the counter so that the
  // following cycle is cnt==0 with period_start high.
  always_comb begin
    run_ok         = pwm_en && (period_act_q != '0);
    go             = run_q && run_ok;
    wrap           = go && (cnt_q >= period_act_q - 1'b1);
    boundary       = wrap || !run_ok;
    cnt_d          = (go && !wrap) ? cnt_q + 1'b1 : '0;
    run_d          = run_ok;
    period_start_d = run_ok && (wrap || !run_q);
    raw            = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      raw[i] = cnt_q < duty_act_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef PWM_DEADTIME_EN
  typedef enum logic [1:0] {ST_OFF, ST_DT, ST_HI, ST_LO} dt_state_e;

  logic [DT_WIDTH-1:0] dt_act_q, dt_act_d;
  logic [DT_WIDTH-1:0] dt_stg_q, dt_stg_d;
  logic [CHANNELS-1:0] raw_prev_q;
  dt_state_e           state_q [CHANNELS];
  dt_state_e           state_d [CHANNELS];
  logic [DT_WIDTH-1:0] dcnt_q  [CHANNELS];
  logic [DT_WIDTH-1:0] dcnt_d  [CHANNELS];
`endif

  // Staging always takes a load; at a boundary the active set is fed from
  // the staging next-value, so a load on the boundary cycle goes straight
  // through and never raises load_pending.
  always_comb begin
    period_stg_d   = load ? pwm_period : period_stg_q;
    duty_stg_d     = load ? duty : duty_stg_q;
    period_act_d   = period_act_q;
    duty_act_d     = duty_act_q;
    load_pending_d = load_pending_q | load;
`ifdef PWM_DEADTIME_EN
    dt_stg_d       = load ? dead_time : dt_stg_q;
    dt_act_d       = dt_act_q;
`endif
    if (boundary) begin
      period_act_d   = period_stg_d;
      duty_act_d     = duty_stg_d;
      load_pending_d = 1'b0;
`ifdef PWM_DEADTIME_EN
      dt_act_d       = dt_stg_d;
`endif
    end
  end

`ifdef PWM_DEADTIME_EN
  // The dead counter is loaded with D-1 on an edge so that the new side
  // asserts exactly D cycles after both outputs dropped.
  always_comb begin
    hi_d = '0;
    lo_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      dcnt_d[i]  = dcnt_q[i];
      if (!go) begin
        state_d[i] = ST_OFF;
        dcnt_d[i]  = '0;
      end else if ((state_q[i] == ST_OFF) || (raw[i] != raw_prev_q[i])) begin
        if (dt_act_q == '0) begin
          hi_d[i]    = raw[i];
          lo_d[i]    = !raw[i];
          state_d[i] = raw[i] ? ST_HI : ST_LO;
        end else begin
          state_d[i] = ST_DT;
          dcnt_d[i]  = dt_act_q - 1'b1;
        end
      end else if (state_q[i] == ST_DT) begin
        if (dcnt_q[i] == '0) begin
          hi_d[i]    = raw[i];
          lo_d[i]    = !raw[i];
          state_d[i] = raw[i] ? ST_HI : ST_LO;
        end else begin
          dcnt_d[i] = dcnt_q[i] - 1'b1;
        end
      end else begin
        hi_d[i] = raw[i];
        lo_d[i] = !raw[i];
      end
    end
  end
`else
  logic unused_dead_time;
  assign unused_dead_time = ^dead_time;

  always_comb begin
    hi_d = go ? raw : '0;
    lo_d = go ? ~raw : '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q          <= '0;
      period_act_q   <= '0;
      period_stg_q   <= '0;
      duty_act_q     <= '0;
      duty_stg_q     <= '0;
      load_pending_q <= 1'b0;
      period_start_q <= 1'b0;
      run_q          <= 1'b0;
      hi_q           <= '0;
      lo_q           <= '0;
`ifdef PWM_DEADTIME_EN
      dt_act_q       <= '0;
      dt_stg_q       <= '0;
      raw_prev_q     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= ST_OFF;
        dcnt_q[i]  <= '0;
      end
`endif
    end else begin
      cnt_q          <= cnt_d;
      period_act_q   <= period_act_d;
      period_stg_q   <= period_stg_d;
      duty_act_q     <= duty_act_d;
      duty_stg_q     <= duty_stg_d;
      load_pending_q <= load_pending_d;
      period_start_q <= period_start_d;
      run_q          <= run_d;
      hi_q           <= hi_d;
      lo_q           <= lo_d;
`ifdef PWM_DEADTIME_EN
      dt_act_q       <= dt_act_d;
      dt_stg_q       <= dt_stg_d;
      raw_prev_q     <= raw;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        dcnt_q[i]  <= dcnt_d[i];
      end
`endif
    end
  end

  assign pwm_hi       = hi_q;
  assign pwm_lo       = lo_q;
  assign period_start = period_start_q;
  assign load_pending = load_pending_q;

endmodule
